// File: rtl/input_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_io_pkg
// Description : Shared constants and elaboration-time helpers for the
//               input_io_bank pad cell (mode names, range checks, counter
//               width).
// Revision    : 1.0 - initial release
// ============================================================================
package input_io_pkg;

  // Mode names accepted by the MODE parameter of input_io_bank
  localparam string C_MODE_BUFF = "in_buff";
  localparam string C_MODE_REG  = "in_reg";
  localparam string C_MODE_FILT = "in_filt";

  // Legal parameter ranges
  localparam int C_WIDTH_MIN = 1;
  localparam int C_WIDTH_MAX = 32;
  localparam int C_SYNC_MIN  = 2;
  localparam int C_SYNC_MAX  = 4;
  localparam int C_FILT_MIN  = 1;
  localparam int C_FILT_MAX  = 15;

  // True when the channel count is supported
  function automatic bit width_ok(input int w);
    return (w >= C_WIDTH_MIN) && (w <= C_WIDTH_MAX);
  endfunction

  // True when the synchroniser depth is supported
  function automatic bit sync_ok(input int s);
    return (s >= C_SYNC_MIN) && (s <= C_SYNC_MAX);
  endfunction

  // True when the filter length is supported
  function automatic bit filt_ok(input int f);
    return (f >= C_FILT_MIN) && (f <= C_FILT_MAX);
  endfunction

  // Bits needed to hold a filter count of 0..FILT_LEN
  function automatic int cnt_width(input int filt_len);
    return (filt_len < 1) ? 1 : $clog2(filt_len + 1);
  endfunction

endpackage : input_io_pkg
`default_nettype wire

// File: rtl/input_io_filt_bit.sv
`default_nettype none
// ============================================================================
// Module      : input_io_filt_bit
// Description : One channel of the filtered input path: a free-running
//               synchroniser, an enable-gated mismatch counter that commits a
//               new level after FILT_LEN enabled mismatch cycles, and the
//               registered rise/fall pulses that accompany each commit.
// Revision    : 1.0 - initial release
// ============================================================================
module input_io_filt_bit
  import input_io_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_a,
  input  logic i_en,
  output logic o_z,
  output logic o_rise,
  output logic o_fall
);

  localparam int               CNT_W     = cnt_width(FILT_LEN);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_z;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;
  logic                   w_mismatch;
  logic                   w_commit;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_mismatch = (w_s != r_z);
  assign w_commit   = w_mismatch && i_en && (r_cnt == C_CNT_MAX);

  // Synchroniser shifts every cycle regardless of the enable
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_a};
    end
  end

  // Mismatch counter: clears on agreement, advances only while enabled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!w_mismatch) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == C_CNT_MAX) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end
    end
  end

  // Output level and its edge pulses update together on a commit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_z    <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_commit && w_s;
      r_fall <= w_commit && !w_s;
      if (w_commit) begin
        r_z <= w_s;
      end
    end
  end

  assign o_z    = r_z;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule : input_io_filt_bit
`default_nettype wire

// File: rtl/input_io_bank.sv
`default_nettype none
// ============================================================================
// Module      : input_io_bank
// Description : WIDTH-channel pad-to-fabric input cell. MODE selects a
//               transparent buffer, a clock-enabled register with edge
//               pulses, or a synchronised, glitch-filtered input with edge
//               pulses (one input_io_filt_bit per channel).
// Revision    : 1.0 - initial release
// ============================================================================
module input_io_bank
  import input_io_pkg::*;
#(
  parameter int    WIDTH       = 4,
  parameter string MODE        = "in_reg",
  parameter int    SYNC_STAGES = 2,
  parameter int    FILT_LEN    = 4,
  parameter logic  RST_VAL     = 1'b0
) (
  input  logic             IQC,
  input  logic             QRT,
  input  logic [WIDTH-1:0] A2F,
  input  logic             IQE,
  output logic [WIDTH-1:0] IQZ,
  output logic [WIDTH-1:0] IQR,
  output logic [WIDTH-1:0] IQF
);

  // Parameter sanity: any illegal combination stops elaboration
  if (!width_ok(WIDTH)) begin : g_err_width
    $error("input_io_bank: WIDTH %0d outside 1..32", WIDTH);
  end
  if (!sync_ok(SYNC_STAGES)) begin : g_err_sync
    $error("input_io_bank: SYNC_STAGES %0d outside 2..4", SYNC_STAGES);
  end
  if (!filt_ok(FILT_LEN)) begin : g_err_filt
    $error("input_io_bank: FILT_LEN %0d outside 1..15", FILT_LEN);
  end

  if (MODE == C_MODE_BUFF) begin : g_buff
    // Clock, reset and enable have no role in the transparent path
    logic w_unused_buff;
    assign w_unused_buff = ^{IQC, QRT, IQE};

    assign IQZ = A2F;
    assign IQR = '0;
    assign IQF = '0;

  end else if (MODE == C_MODE_REG) begin : g_reg
    logic [WIDTH-1:0] r_iqz;
    logic [WIDTH-1:0] r_iqr;
    logic [WIDTH-1:0] r_iqf;

    // Capture the pad when enabled; pulses flag bits that changed at this edge
    always_ff @(posedge IQC or posedge QRT) begin
      if (QRT) begin
        r_iqz <= {WIDTH{RST_VAL}};
        r_iqr <= '0;
        r_iqf <= '0;
      end else if (IQE) begin
        r_iqz <= A2F;
        r_iqr <= A2F & ~r_iqz;
        r_iqf <= ~A2F & r_iqz;
      end else begin
        r_iqr <= '0;
        r_iqf <= '0;
      end
    end

    assign IQZ = r_iqz;
    assign IQR = r_iqr;
    assign IQF = r_iqf;

  end else if (MODE == C_MODE_FILT) begin : g_filt
    // Independent filter per channel; nothing is shared between bits
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      input_io_filt_bit #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN),
        .RST_VAL     (RST_VAL)
      ) u_bit (
        .i_clk  (IQC),
        .i_rst  (QRT),
        .i_a    (A2F[i]),
        .i_en   (IQE),
        .o_z    (IQZ[i]),
        .o_rise (IQR[i]),
        .o_fall (IQF[i])
      );
    end

  end else begin : g_err_mode
    $error("input_io_bank: unsupported MODE \"%s\"", MODE);
    logic w_unused_mode;
    assign w_unused_mode = ^{IQC, QRT, IQE, A2F};
    assign IQZ = '0;
    assign IQR = '0;
    assign IQF = '0;
  end

endmodule : input_io_bank
`default_nettype wire
